lsu: RTL and testbench

Load/store unit for the RISC-V core, directly downstream of the ALU. Takes the ALU result as the effective address and the second register operand as store data. Issues one word-aligned request on a req/ack data-bus handshake with byte enables, and stalls the core until the access completes. Aligns, sign-extends or zero-extends load data for register writeback, and flags misaligned or illegal accesses without touching the bus.

---
 rtl/lsu.sv | 198 +++++++++++++++++++
 tb/tb_lsu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit sitting directly after the ALU.
//
// It takes the ALU result as the effective address and rs2 as the store data.
// Each legal access issues one word-aligned request on a req/ack bus with byte
// enables, and the core is stalled until that request completes. Load data is
// aligned, then sign- or zero-extended for writeback. Misaligned accesses and
// illegal funct3 codes raise a fault and never touch the bus.
//
// Optional feature: define LSU_TIMEOUT_EN to add an ack watchdog. If no ack
// arrives within TIMEOUT request cycles, the request is dropped and a fault
// is raised.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   mem_en, mem_we   access request from the core (1 = store, 0 = load)
//   funct3           access size and sign
//   addr, wdata      effective address and store data
//   stall            holds the PC and pipeline inputs
//   rdata            extended load result
//   rdata_valid      one-cycle pulse when rdata is ready for writeback
//   fault            one-cycle pulse for a misaligned, illegal or timed-out access
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata   registered bus request
//   bus_ack, bus_rdata                             bus completion and read data
module lsu #(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_en,
    input  logic               mem_we,
    input  logic [2:0]         funct3,
    input  logic [D_WIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0] wdata,
    output logic               stall,
    output logic [D_WIDTH-1:0] rdata,
    output logic               rdata_valid,
    output logic               fault,
    output logic               bus_req,
    output logic               bus_we,
    output logic [D_WIDTH-1:0] bus_addr,
    output logic [3:0]         bus_be,
    output logic [D_WIDTH-1:0] bus_wdata,
    input  logic               bus_ack,
    input  logic [D_WIDTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e             state_q, state_d;
    logic               we_q;
    logic [2:0]         funct3_q;
    logic [1:0]         off_q;
    logic               fault_q;
    logic [D_WIDTH-1:0] rdata_q;
    logic [D_WIDTH-1:0] bus_addr_q;
    logic [3:0]         bus_be_q;
    logic [D_WIDTH-1:0] bus_wdata_q;

    logic               legal;
    logic [3:0]         be_calc;
    logic [D_WIDTH-1:0] wdata_calc;
    logic [D_WIDTH-1:0] load_ext;
    logic               timeout_hit;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CntW-1:0] cnt_q;

    // The final counted cycle is TIMEOUT-1. An ack in that cycle takes priority.
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    // Legality check, byte enables and lane-replicated store data for the
    // access presented in IDLE.
    always_comb begin
        legal      = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        unique case (funct3)
            3'b000:         legal = 1'b1;
            3'b001:         legal = ~addr[0];
            3'b010:         legal = (addr[1:0] == 2'b00);
            3'b100, 3'b101: legal = ~mem_we & (~funct3[0] | ~addr[0]);
            default:        legal = 1'b0;
        endcase
        unique case (funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {(D_WIDTH/8){wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {(D_WIDTH/16){wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata;
            end
        endcase
    end

    // Select the lane addressed by the latched offset, then extend it.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = bus_rdata[{off_q, 3'b000} +: 8];
        half_sel = bus_rdata[{off_q[1], 4'b0000} +: 16];
        load_ext = bus_rdata;
        unique case (funct3_q)
            3'b000:  load_ext = {{(D_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{(D_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_ext = {{(D_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_ext = {{(D_WIDTH-16){1'b0}}, half_sel};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (mem_en) state_d = legal ? StReq : StDone;
            StReq:  if (bus_ack || timeout_hit) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (mem_en) begin
                        if (legal) begin
                            we_q        <= mem_we;
                            funct3_q    <= funct3;
                            off_q       <= addr[1:0];
                            fault_q     <= 1'b0;
                            bus_addr_q  <= {addr[D_WIDTH-1:2], 2'b00};
                            bus_be_q    <= be_calc;
                            bus_wdata_q <= wdata_calc;
`ifdef LSU_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                        end else begin
                            fault_q <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                StReq: begin
                    if (bus_ack) begin
                        if (!we_q) rdata_q <= load_ext;
                    end else if (timeout_hit) begin
                        fault_q <= 1'b1;
                        rdata_q <= '0;
                    end
`ifdef LSU_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign stall       = mem_en & (state_q != StDone);
    assign bus_req     = (state_q == StReq);
    assign bus_we      = bus_req & we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
    assign rdata       = rdata_q;
    // A fault always has priority over the load-complete pulse.
    assign rdata_valid = (state_q == StDone) & ~fault_q & ~we_q;
    assign fault       = (state_q == StDone) & fault_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit. Inputs change 1 ns after the rising
// edge, and outputs are checked in that same window.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;

    lsu #(.D_WIDTH(32), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .fault       (fault),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Legal access with the ack in the first REQ cycle. The full handshake is
    // checked from T0 through T2.
    task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        mem_en = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        #1;
        chk({tag, "_t0_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, "_t0_req"}, {31'd0, bus_req}, 32'd0);
        tick();
        chk({tag, "_t1_req"}, {31'd0, bus_req}, 32'd1);
        chk({tag, "_t1_we"}, {31'd0, bus_we}, {31'd0, we});
        chk({tag, "_t1_addr"}, bus_addr, exp_addr);
        chk({tag, "_t1_be"}, {28'd0, bus_be}, {28'd0, exp_be});
        if (we) chk({tag, "_t1_wdata"}, bus_wdata, exp_wd);
        chk({tag, "_t1_stall"}, {31'd0, stall}, 32'd1);
        bus_ack = 1'b1; bus_rdata = rd;
        tick();
        bus_ack = 1'b0;
        chk({tag, "_t2_valid"}, {31'd0, rdata_valid}, {31'd0, ~we});
        chk({tag, "_t2_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_t2_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_t2_rdata"}, rdata, exp_rd);
        mem_en = 1'b0;
        tick();
        chk({tag, "_idle_valid"}, {31'd0, rdata_valid}, 32'd0);
    endtask

    // Illegal access: the fault must appear at T1 with no bus request.
    task automatic flt(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a);
        mem_en = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = 32'hFFFF_FFFF;
        #1;
        chk({tag, "_t0_stall"}, {31'd0, stall}, 32'd1);
        tick();
        chk({tag, "_t1_fault"}, {31'd0, fault}, 32'd1);
        chk({tag, "_t1_req"}, {31'd0, bus_req}, 32'd0);
        chk({tag, "_t1_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_t1_valid"}, {31'd0, rdata_valid}, 32'd0);
        chk({tag, "_t1_rdata"}, rdata, 32'd0);
        mem_en = 1'b0;
        tick();
        chk({tag, "_t2_fault"}, {31'd0, fault}, 32'd0);
    endtask

    initial begin
        int nreq;
        rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_we", {31'd0, bus_we}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // LB 0x1003: lane 3 = 0x80, sign-extended
        xfer("lb", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234,
             32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
        // LHU 0x2002: upper half, zero-extended
        xfer("lhu", 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h9ABC_0000,
             32'h0000_2000, 4'b1100, 32'h0, 32'h0000_9ABC);
        // LH 0x20: lower half 0xF00D, sign-extended
        xfer("lh", 1'b0, 3'b001, 32'h0000_0020, 32'h0, 32'h1234_F00D,
             32'h0000_0020, 4'b0011, 32'h0, 32'hFFFF_F00D);
        // LBU 0x1: byte 1 = 0x90, zero-extended
        xfer("lbu", 1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_9000,
             32'h0000_0000, 4'b0010, 32'h0, 32'h0000_0090);
        // SW: data passes through, and rdata keeps the last load value
        xfer("sw", 1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_BABE, 32'h1111_1111,
             32'h0000_0040, 4'b1111, 32'hCAFE_BABE, 32'h0000_0090);
        // SH 0x42: upper lanes, half replicated
        xfer("sh", 1'b1, 3'b001, 32'h0000_0042, 32'h0000_BEEF, 32'h0,
             32'h0000_0040, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0090);

        // An ack while idle must not start anything.
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("idle_ack_req", {31'd0, bus_req}, 32'd0);
        chk("idle_ack_valid", {31'd0, rdata_valid}, 32'd0);

        // SB 0x10 with the ack on the 4th REQ cycle; an address change during REQ is ignored.
        mem_en = 1'b1; mem_we = 1'b1; funct3 = 3'b000; addr = 32'h10; wdata = 32'h1234_56A5;
        tick();
        addr = 32'hFFFF_FFFF;
        chk("sb_we", {31'd0, bus_we}, 32'd1);
        chk("sb_be", {28'd0, bus_be}, 32'h1);
        chk("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus_req) nreq++;
            chk("sb_addr_hold", bus_addr, 32'h0000_0010);
            chk("sb_stall", {31'd0, stall}, 32'd1);
            if (i == 3) bus_ack = 1'b1;
            tick();
        end
        bus_ack = 1'b0;
        chk("sb_req_cycles", nreq, 32'd4);
        chk("sb_done_req", {31'd0, bus_req}, 32'd0);
        chk("sb_done_valid", {31'd0, rdata_valid}, 32'd0);
        chk("sb_done_fault", {31'd0, fault}, 32'd0);
        chk("sb_rdata_hold", rdata, 32'h0000_0090);
        mem_en = 1'b0;
        tick();

        flt("lw_mis", 1'b0, 3'b010, 32'h0000_4001);
        flt("sh_mis", 1'b1, 3'b001, 32'h0000_0011);
        flt("ld_f3_011", 1'b0, 3'b011, 32'h0000_0000);
        flt("st_f3_100", 1'b1, 3'b100, 32'h0000_0000);

        // A reset during REQ must drop the request without any completion pulse.
        mem_en = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h3000;
        tick();
        chk("rstmid_req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1; mem_en = 1'b0;
        tick();
        rst = 1'b0;
        chk("rstmid_req_drop", {31'd0, bus_req}, 32'd0);
        chk("rstmid_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rstmid_fault", {31'd0, fault}, 32'd0);
        tick();
        chk("rstmid_valid2", {31'd0, rdata_valid}, 32'd0);
        xfer("lw_after_rst", 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF,
             32'h0000_3000, 4'b1111, 32'h0, 32'hDEAD_BEEF);

`ifdef LSU_TIMEOUT_EN
        // Never ack: the request should drop after 16 REQ cycles with one fault pulse.
        mem_en = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h5000;
        tick();
        nreq = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus_req) break;
            nreq++;
            tick();
        end
        chk("to_req_cycles", nreq, 32'd16);
        chk("to_fault", {31'd0, fault}, 32'd1);
        chk("to_rdata", rdata, 32'd0);
        mem_en = 1'b0;
        tick();
        chk("to_fault_once", {31'd0, fault}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
